// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single backing memory.
//   Only one transaction is outstanding at a time. The fetch port (icache) is
//   read-only. The data port (dcache) issues loads and stores. A wait counter
//   aborts a memory access that is never acknowledged. An aborted access returns
//   ERR_DATA and sets the sticky bus_err flag.
//
// Ports
//   ctrl_clk, ctrl_reset               clock and asynchronous active-high reset
//   icache_req/addr                    fetch request, held until icache_rdy
//   icache_data/rdy                    fetch read data and a one-cycle completion pulse
//   dcache_req/addr/wdata/wen          data request, held until dcache_rdy
//   dcache_rdata/rdy                   load data and a one-cycle completion pulse
//   mem_req/addr/wdata/wen             registered memory command, stable while mem_req=1
//   mem_ack, mem_rdata                 memory completion and read data
//   bus_err                            sticky timeout flag, cleared only by reset
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_reset,
  input  logic        icache_req,
  input  logic [31:0] icache_addr,
  output logic [31:0] icache_data,
  output logic        icache_rdy,
  input  logic        dcache_req,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  input  logic        dcache_wen,
  output logic [31:0] dcache_rdata,
  output logic        dcache_rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Grant owner encoding: 0 = fetch port, 1 = data port.
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // The counter holds the number of un-acknowledged BUSY cycles completed so far.
  // The abort fires on the edge that ends the TIMEOUT-th such cycle.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic        r_owner;
  logic [15:0] r_wait_cnt;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_wen;
  logic [31:0] r_icache_data;
  logic        r_icache_rdy;
  logic [31:0] r_dcache_rdata;
  logic        r_dcache_rdy;
  logic        r_bus_err;

  logic        w_any_req;
  logic        w_grant_d;
  logic        w_ack;
  logic        w_timeout;
  logic [31:0] w_resp_data;

  always_comb begin
    w_state_nxt = r_state;
    w_any_req   = icache_req | dcache_req;
    // The data port wins when it is the only requester. When both ports
    // request, it wins if the fetch port had the previous grant.
    w_grant_d   = dcache_req & (~icache_req | (r_last_grant == GNT_I));
    w_ack       = (r_state == BUSY) & mem_ack;
    w_timeout   = (r_state == BUSY) & ~mem_ack & (r_wait_cnt == WAIT_LAST);
    w_resp_data = w_ack ? mem_rdata : ERR_DATA;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = BUSY;
      BUSY:    if (w_ack || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_last_grant   <= GNT_I;
      r_owner        <= GNT_I;
      r_wait_cnt     <= '0;
      r_mem_req      <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_wen      <= 1'b0;
      r_icache_data  <= '0;
      r_icache_rdy   <= 1'b0;
      r_dcache_rdata <= '0;
      r_dcache_rdy   <= 1'b0;
      r_bus_err      <= 1'b0;
    end else begin
      // Each rdy signal is high only in the cycle after completion, while the state is RESP.
      r_icache_rdy <= 1'b0;
      r_dcache_rdy <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_mem_req    <= 1'b1;
            r_mem_addr   <= w_grant_d ? dcache_addr : icache_addr;
            r_mem_wdata  <= w_grant_d ? dcache_wdata : 32'h0;
            r_mem_wen    <= w_grant_d & dcache_wen;
            r_owner      <= w_grant_d;
            r_last_grant <= w_grant_d;
            r_wait_cnt   <= '0;
          end
        end
        BUSY: begin
          if (w_ack || w_timeout) begin
            r_mem_req <= 1'b0;
            // A store also updates the read data with mem_rdata.
            if (r_owner == GNT_D) begin
              r_dcache_rdata <= w_resp_data;
              r_dcache_rdy   <= 1'b1;
            end else begin
              r_icache_data  <= w_resp_data;
              r_icache_rdy   <= 1'b1;
            end
            if (w_timeout) r_bus_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_wen      = r_mem_wen;
  assign icache_data  = r_icache_data;
  assign icache_rdy   = r_icache_rdy;
  assign dcache_rdata = r_dcache_rdata;
  assign dcache_rdy   = r_dcache_rdy;
  assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        ctrl_reset;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic [31:0] icache_data;
  logic        icache_rdy;
  logic        dcache_req;
  logic [31:0] dcache_addr;
  logic [31:0] dcache_wdata;
  logic        dcache_wen;
  logic [31:0] dcache_rdata;
  logic        dcache_rdy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .ctrl_clk    (clk),
    .ctrl_reset  (ctrl_reset),
    .icache_req  (icache_req),
    .icache_addr (icache_addr),
    .icache_data (icache_data),
    .icache_rdy  (icache_rdy),
    .dcache_req  (dcache_req),
    .dcache_addr (dcache_addr),
    .dcache_wdata(dcache_wdata),
    .dcache_wen  (dcache_wen),
    .dcache_rdata(dcache_rdata),
    .dcache_rdy  (dcache_rdy),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wen     (mem_wen),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One memory transaction, observed at negedges. 'hold' is the number of
  // cycles mem_req is expected high. If do_ack is set, mem_ack is driven in
  // the last of those cycles.
  task automatic do_txn(input string tag, input logic [31:0] e_addr, input logic e_wen,
                        input logic [31:0] e_wdata, input int hold, input bit do_ack,
                        input logic [31:0] rdata, input bit own_d, input logic [31:0] e_data,
                        input bit drop_i, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!mem_req && waited < 10);
    chk({tag, "_req"}, {31'h0, mem_req}, 32'h1);
    chk({tag, "_addr"}, mem_addr, e_addr);
    chk({tag, "_wen"}, {31'h0, mem_wen}, {31'h0, e_wen});
    chk({tag, "_wdata"}, mem_wdata, e_wdata);
    if (drop_i) icache_req = 1'b0;
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_req"}, {31'h0, mem_req}, 32'h1);
      chk({tag, "_hold_addr"}, mem_addr, e_addr);
      chk({tag, "_hold_wen"}, {31'h0, mem_wen}, {31'h0, e_wen});
      chk({tag, "_hold_wdata"}, mem_wdata, e_wdata);
    end
    if (do_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = rdata;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk({tag, "_req_drop"}, {31'h0, mem_req}, 32'h0);
    chk({tag, "_irdy"}, {31'h0, icache_rdy}, {31'h0, !own_d});
    chk({tag, "_drdy"}, {31'h0, dcache_rdy}, {31'h0, own_d});
    chk({tag, "_data"}, own_d ? dcache_rdata : icache_data, e_data);
    @(negedge clk);
    chk({tag, "_rdy_off"}, {30'h0, icache_rdy, dcache_rdy}, 32'h0);
    chk({tag, "_data_hold"}, own_d ? dcache_rdata : icache_data, e_data);
  endtask

  int w;

  initial begin
    ctrl_reset   = 1'b1;
    icache_req   = 1'b0;
    icache_addr  = '0;
    dcache_req   = 1'b0;
    dcache_addr  = '0;
    dcache_wdata = '0;
    dcache_wen   = 1'b0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_wen", {31'h0, mem_wen}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdy", {30'h0, icache_rdy, dcache_rdy}, 32'h0);
    chk("rst_idata", icache_data, 32'h0);
    chk("rst_ddata", dcache_rdata, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    ctrl_reset = 1'b0;

    // Fetch only, ack in the first mem_req cycle.
    icache_req  = 1'b1;
    icache_addr = 32'h100;
    do_txn("fetch", 32'h100, 1'b0, 32'h0, 1, 1'b1, 32'h13, 1'b0, 32'h13, 1'b0, w);
    chk("fetch_lat", w, 32'd1);
    icache_req = 1'b0;

    // Contention after reset: the data port wins first, then grants alternate.
    @(negedge clk);
    ctrl_reset = 1'b1;
    @(negedge clk);
    ctrl_reset  = 1'b0;
    icache_req  = 1'b1;
    icache_addr = 32'h200;
    dcache_req  = 1'b1;
    dcache_addr = 32'h8000;
    do_txn("rr0", 32'h8000, 1'b0, 32'h0, 1, 1'b1, 32'hD0000001, 1'b1, 32'hD0000001, 1'b0, w);
    do_txn("rr1", 32'h200,  1'b0, 32'h0, 1, 1'b1, 32'h10000002, 1'b0, 32'h10000002, 1'b0, w);
    do_txn("rr2", 32'h8000, 1'b0, 32'h0, 1, 1'b1, 32'hD0000003, 1'b1, 32'hD0000003, 1'b0, w);
    do_txn("rr3", 32'h200,  1'b0, 32'h0, 1, 1'b1, 32'h10000004, 1'b0, 32'h10000004, 1'b0, w);
    icache_req = 1'b0;
    dcache_req = 1'b0;

    // Store with three wait cycles before the ack.
    dcache_req   = 1'b1;
    dcache_wen   = 1'b1;
    dcache_addr  = 32'h40;
    dcache_wdata = 32'hCAFEF00D;
    do_txn("store", 32'h40, 1'b1, 32'hCAFEF00D, 4, 1'b1, 32'h5555AAAA, 1'b1, 32'h5555AAAA, 1'b0, w);
    dcache_req = 1'b0;
    dcache_wen = 1'b0;
    chk("store_no_err", {31'h0, bus_err}, 32'h0);

    // Timeout with TIMEOUT=4: no ack, error data returned, bus_err stays set.
    icache_req  = 1'b1;
    icache_addr = 32'h300;
    do_txn("tmo", 32'h300, 1'b0, 32'h0, 4, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, w);
    chk("tmo_bus_err", {31'h0, bus_err}, 32'h1);
    icache_addr = 32'h304;
    do_txn("after_tmo", 32'h304, 1'b0, 32'h0, 2, 1'b1, 32'h77, 1'b0, 32'h77, 1'b0, w);
    icache_req = 1'b0;
    chk("sticky_bus_err", {31'h0, bus_err}, 32'h1);

    // Reset asserted between edges while mem_req=1.
    icache_req  = 1'b1;
    icache_addr = 32'h400;
    @(negedge clk);
    chk("mid_req", {31'h0, mem_req}, 32'h1);
    #2 ctrl_reset = 1'b1;
    #1;
    chk("async_req", {31'h0, mem_req}, 32'h0);
    chk("async_bus_err", {31'h0, bus_err}, 32'h0);
    chk("async_idata", icache_data, 32'h0);
    icache_req = 1'b0;
    @(negedge clk);
    ctrl_reset = 1'b0;
    mem_ack    = 1'b1;
    mem_rdata  = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_rdy", {30'h0, icache_rdy, dcache_rdy}, 32'h0);
    chk("stray_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    chk("stray_rdy2", {30'h0, icache_rdy, dcache_rdy}, 32'h0);
    chk("stray_idata", icache_data, 32'h0);
    icache_req  = 1'b1;
    icache_addr = 32'h600;
    do_txn("post_rst", 32'h600, 1'b0, 32'h0, 1, 1'b1, 32'h99, 1'b0, 32'h99, 1'b0, w);
    icache_req = 1'b0;

    // Fetch request dropped while BUSY still completes.
    icache_req  = 1'b1;
    icache_addr = 32'h500;
    do_txn("drop", 32'h500, 1'b0, 32'h0, 2, 1'b1, 32'hABCD, 1'b0, 32'hABCD, 1'b1, w);
    @(negedge clk);
    chk("drop_no_regrant", {31'h0, mem_req}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
